vga_fb_arbiter: RTL

//  Shares one single-port framebuffer RAM between the VGA scan-out path and a pixel writer.

---
 rtl/vga_fb_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: shares one single-port video RAM between VGA scan-out,
// a handshaked pixel writer and a clear-screen engine. Scan-out reads always
// own their slot; writes and clears only use the remaining RAM cycles.
module vga_fb_arbiter #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DATA_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic              valid,
    input  logic [9:0]        h_addr,
    input  logic [9:0]        v_addr,
    input  logic              frame_start,
    input  logic [1:0]        mode_in,
    output logic [1:0]        mode_cur,
    output logic [DATA_W-1:0] vga_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned       PIX_TOTAL = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] PIX_CNT   = ADDR_W'(PIX_TOTAL);
    localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(PIX_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_slot;
    logic              free_slot;
    logic              wr_in_range;
    logic              clr_last;
    logic              wr_fire;
    logic              clr_fire;
    logic              rd_pend;

    // Slot classification and scan-out address
    assign scan_slot   = pix_en & valid;
    assign free_slot   = ~scan_slot;
    assign scan_addr   = ADDR_W'(v_addr) * ADDR_W'(H_ACTIVE) + ADDR_W'(h_addr);
    assign wr_in_range = (wr_addr < PIX_CNT);
    assign clr_last    = (clr_cnt == PIX_LAST);

    // Next state and RAM port mux; a scan slot always leaves the RAM to scan-out
    always_comb begin
        state_nxt = state;
        ram_addr  = scan_addr;
        ram_we    = 1'b0;
        ram_wdata = '0;
        wr_fire   = 1'b0;
        clr_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                end else if (wr_req && free_slot) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (free_slot) begin
                    ram_addr  = wr_addr;
                    ram_we    = wr_in_range && !rst;
                    ram_wdata = wr_data;
                    wr_fire   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            CLEAR: begin
                if (free_slot) begin
                    ram_addr  = clr_cnt;
                    ram_we    = !rst;
                    ram_wdata = '0;
                    clr_fire  = 1'b1;
                    if (clr_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Clear address counter; parked at 0 whenever the engine is not running
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (clr_fire) begin
            clr_cnt <= clr_last ? '0 : clr_cnt + ADDR_W'(1);
        end else if (state != CLEAR) begin
            clr_cnt <= '0;
        end
    end

    // Writer handshake and clear status
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            wr_ack   <= wr_fire;
            wr_err   <= wr_fire & ~wr_in_range;
            clr_busy <= (state_nxt == CLEAR);
            clr_done <= clr_fire & clr_last;
        end
    end

    // Scan-out return: capture RAM data one clk after the read slot, blank outside video
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            vga_data <= '0;
        end else begin
            rd_pend <= scan_slot;
            if (rd_pend) begin
                vga_data <= ram_rdata;
            end else if (pix_en && !valid) begin
                vga_data <= '0;
            end
        end
    end

    // Display mode only changes at frame boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_cur <= 2'd0;
        end else if (frame_start) begin
            mode_cur <= mode_in;
        end
    end

endmodule
